// File: rtl/simd32_exec_top.sv
// SIMD execution unit: decode/read, per-lane execute, writeback over a
// per-wavefront vector register file, with RAW stall against the E stage.
module simd32_exec_top #(
  parameter int LANES     = 4,
  parameter int NUM_WF    = 4,
  parameter int WF_BITS   = 2,
  parameter int NUM_VREGS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           inst,
  input  logic [WF_BITS-1:0]    wavefront_num,
  output logic                  decoder_stall,
  output logic                  wb_valid,
  output logic [WF_BITS-1:0]    wb_wf,
  output logic [3:0]            wb_reg,
  output logic [LANES*32-1:0]   wb_data
);

  localparam int DATA_W = 32;
  localparam int VW     = LANES * DATA_W;
  localparam int RF_N   = NUM_WF * NUM_VREGS;

  function automatic logic [DATA_W-1:0] exec_lane(
    input logic [5:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [15:0]       imm,
    input logic [DATA_W-1:0] lane_id
  );
    logic signed [DATA_W-1:0] sa;
    logic        [DATA_W-1:0] simm;
    logic        [DATA_W-1:0] r;
    sa   = a;
    simm = {{16{imm[15]}}, imm};
    case (op)
      6'h01:   r = a + b;
      6'h02:   r = a - b;
      6'h03:   r = a & b;
      6'h04:   r = a | b;
      6'h05:   r = a ^ b;
      6'h06:   r = a * b;
      6'h07:   r = a << b[4:0];
      6'h08:   r = a >> b[4:0];
      6'h09:   r = $unsigned(sa >>> b[4:0]);
      6'h0A:   r = simm;
      6'h0B:   r = a + simm;
      6'h0C:   r = lane_id;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [VW-1:0] rf_q [RF_N];

  logic [5:0]  op_p0;
  logic [3:0]  vd_p0, vs0_p0, vs1_p0;
  logic [15:0] imm_p0;
  logic        use_s0_p0, use_s1_p0, wr_p0, hazard_p0;

  logic               vld_p1_q, vld_p1_d;
  logic [5:0]         op_p1_q, op_p1_d;
  logic [WF_BITS-1:0] wf_p1_q, wf_p1_d;
  logic [3:0]         vd_p1_q, vd_p1_d;
  logic [15:0]        imm_p1_q, imm_p1_d;
  logic [VW-1:0]      a_p1_q, a_p1_d, b_p1_q, b_p1_d;
  logic [VW-1:0]      res_p1;

  logic               wb_valid_q, wb_valid_d;
  logic [WF_BITS-1:0] wb_wf_q, wb_wf_d;
  logic [3:0]         wb_reg_q, wb_reg_d;
  logic [VW-1:0]      wb_data_q, wb_data_d;

  // D stage: decode, hazard detect, register read with W-stage bypass
  always_comb begin
    op_p0     = inst[31:26];
    vd_p0     = inst[25:22];
    vs0_p0    = inst[21:18];
    vs1_p0    = inst[17:14];
    imm_p0    = inst[15:0];
    use_s1_p0 = (op_p0 >= 6'h01) && (op_p0 <= 6'h09);
    use_s0_p0 = use_s1_p0 || (op_p0 == 6'h0B);
    wr_p0     = (op_p0 >= 6'h01) && (op_p0 <= 6'h0C);
    hazard_p0 = vld_p1_q && (wf_p1_q == wavefront_num) &&
                ((use_s0_p0 && (vs0_p0 == vd_p1_q)) ||
                 (use_s1_p0 && (vs1_p0 == vd_p1_q)));

    vld_p1_d = wr_p0 && !hazard_p0;
    op_p1_d  = op_p0;
    wf_p1_d  = wavefront_num;
    vd_p1_d  = vd_p0;
    imm_p1_d = imm_p0;
    a_p1_d   = rf_q[{wavefront_num, vs0_p0}];
    b_p1_d   = rf_q[{wavefront_num, vs1_p0}];
    if (wb_valid_q && (wb_wf_q == wavefront_num) && (wb_reg_q == vs0_p0))
      a_p1_d = wb_data_q;
    if (wb_valid_q && (wb_wf_q == wavefront_num) && (wb_reg_q == vs1_p0))
      b_p1_d = wb_data_q;
  end

  assign decoder_stall = hazard_p0 && !reset;

  // E stage: per-lane execute
  always_comb begin
    res_p1 = '0;
    for (int l = 0; l < LANES; l++)
      res_p1[l*DATA_W +: DATA_W] = exec_lane(op_p1_q, a_p1_q[l*DATA_W +: DATA_W],
                                             b_p1_q[l*DATA_W +: DATA_W], imm_p1_q,
                                             DATA_W'(l));
    wb_valid_d = vld_p1_q;
    wb_wf_d    = wf_p1_q;
    wb_reg_d   = vd_p1_q;
    wb_data_d  = res_p1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_wf_q    <= '0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      wb_valid_q <= wb_valid_d;
      wb_wf_q    <= wb_wf_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
    end
  end

  always_ff @(posedge clk) begin
    op_p1_q  <= op_p1_d;
    wf_p1_q  <= wf_p1_d;
    vd_p1_q  <= vd_p1_d;
    imm_p1_q <= imm_p1_d;
    a_p1_q   <= a_p1_d;
    b_p1_q   <= b_p1_d;
  end

  // W stage: register file commit
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RF_N; i++)
        rf_q[i] <= '0;
    end else if (wb_valid_q) begin
      rf_q[{wb_wf_q, wb_reg_q}] <= wb_data_q;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_wf    = wb_wf_q;
  assign wb_reg   = wb_reg_q;
  assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_simd32_exec_top.sv
// Scoreboard bench for simd32_exec_top: expected writebacks queued at issue,
// compared when wb_valid appears.
module tb_simd32_exec_top;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  inst = '0;
  logic [1:0]   wavefront_num = '0;
  logic         decoder_stall;
  logic         wb_valid;
  logic [1:0]   wb_wf;
  logic [3:0]   wb_reg;
  logic [127:0] wb_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [1:0]   wf;
    logic [3:0]   rd;
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  simd32_exec_top #(.LANES(4), .NUM_WF(4), .WF_BITS(2), .NUM_VREGS(16)) dut (
    .clk(clk),
    .reset(reset),
    .inst(inst),
    .wavefront_num(wavefront_num),
    .decoder_stall(decoder_stall),
    .wb_valid(wb_valid),
    .wb_wf(wb_wf),
    .wb_reg(wb_reg),
    .wb_data(wb_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one instruction, wait for acceptance, queue its expected writeback.
  task automatic issue(input logic [31:0] ins, input logic [1:0] wf, input bit exp_wr,
                       input logic [127:0] exp_data, input int exp_stall, input string tag);
    int st;
    bit acc;
    st  = 0;
    acc = 1'b0;
    #1;
    inst = ins;
    wavefront_num = wf;
    for (int k = 0; k < 8 && !acc; k++) begin
      @(negedge clk);
      if (decoder_stall) st++;
      else begin
        acc = 1'b1;
        if (exp_wr) sb.push_back('{wf, ins[25:22], exp_data, cyc + 2});
      end
      @(posedge clk);
    end
    if (!acc) chk({tag, "_accept_timeout"}, 128'(0), 128'(1));
    chk({tag, "_stall"}, 128'(st), 128'(exp_stall));
  endtask

  task automatic nop();
    issue(32'h0, 2'd0, 1'b0, '0, 0, "nop");
  endtask

  always @(negedge clk) begin
    if (wb_valid) begin
      if (sb.size() == 0) chk("wb_unexpected", 128'(1), 128'(0));
      else begin
        mon_e = sb.pop_front();
        chk("wb_wf", 128'(wb_wf), 128'(mon_e.wf));
        chk("wb_reg", 128'(wb_reg), 128'(mon_e.rd));
        chk("wb_data", wb_data, mon_e.data);
        chk("wb_cycle", 128'(cyc), 128'(mon_e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 128'(decoder_stall), 128'(0));
    chk("rst_wb_valid", 128'(wb_valid), 128'(0));
    chk("rst_wb_wf", 128'(wb_wf), 128'(0));
    chk("rst_wb_reg", 128'(wb_reg), 128'(0));
    chk("rst_wb_data", wb_data, 128'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_stall", 128'(decoder_stall), 128'(0));
      chk("idle_wb_valid", 128'(wb_valid), 128'(0));
      @(posedge clk);
    end

    issue(32'h28400005, 2'd0, 1'b1, {4{32'h00000005}}, 0, "vmovi_v1");
    issue(32'h2880FFFD, 2'd0, 1'b1, {4{32'hFFFFFFFD}}, 0, "vmovi_v2");
    issue(32'h04C48000, 2'd0, 1'b1, {4{32'h00000002}}, 1, "vadd_raw");

    issue(32'h28400007, 2'd1, 1'b1, {4{32'h00000007}}, 0, "vmovi_wf1");
    issue(32'h04C48000, 2'd0, 1'b1, {4{32'h00000002}}, 0, "vadd_xwf");
    // imm field aliases vs1=v3 (in E), which VADDI must not treat as a source
    issue(32'h2EC4FFFA, 2'd0, 1'b1, {4{32'hFFFFFFFF}}, 0, "vaddi_neg");
    issue(32'hFEEC0000, 2'd0, 1'b0, '0, 0, "bad_op");

    issue(32'h31000000, 2'd0, 1'b1, 128'h00000003_00000002_00000001_00000000, 0, "vlaneid");
    nop();
    issue(32'h1D510000, 2'd0, 1'b1, 128'h00000018_00000008_00000002_00000000, 0, "vsll");
    issue(32'h09848000, 2'd0, 1'b1, {4{32'h00000008}}, 0, "vsub");
    issue(32'h19C88000, 2'd0, 1'b1, {4{32'h00000009}}, 0, "vmul");
    issue(32'h26090000, 2'd0, 1'b1, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFD, 0, "vsra");
    issue(32'h22490000, 2'd0, 1'b1, 128'h1FFFFFFF_3FFFFFFF_7FFFFFFE_FFFFFFFD, 0, "vsrl");
    issue(32'h16848000, 2'd0, 1'b1, {4{32'hFFFFFFF8}}, 0, "vxor");
    issue(32'h13050000, 2'd0, 1'b1, 128'h00000007_00000007_00000005_00000005, 0, "vor");

    issue(32'h2B408000, 2'd2, 1'b1, {4{32'hFFFF8000}}, 0, "vmovi_v13");
    issue(32'h2FB40001, 2'd2, 1'b1, {4{32'hFFFF8001}}, 1, "vaddi_raw");

    repeat (3) nop();
    chk("sb_drained", 128'(sb.size()), 128'(0));

    // VADD enters E, then reset discards it
    issue(32'h04C48000, 2'd0, 1'b0, '0, 0, "vadd_killed");
    #1;
    reset = 1'b1;
    inst = '0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_wb_valid", 128'(wb_valid), 128'(0));
    chk("midrst_stall", 128'(decoder_stall), 128'(0));
    chk("midrst_wb_data", wb_data, 128'(0));
    @(posedge clk);
    @(negedge clk);
    chk("midrst_wb_valid2", 128'(wb_valid), 128'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    issue(32'h2D8C0000, 2'd0, 1'b1, 128'(0), 0, "vaddi_after_rst");
    issue(32'h04C48000, 2'd0, 1'b1, 128'(0), 0, "vadd_after_rst");

    repeat (3) nop();
    chk("sb_empty_end", 128'(sb.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simd32_exec_top.md
Name: simd32_exec_top

Overview:
- Top of a single SIMD execution unit: accepts one 32-bit vector instruction per clock, decodes it, reads per-wavefront vector registers, executes across LANES 32-bit lanes, writes back.
- 3-stage pipeline: Decode/Read (D), Execute (E), Writeback (W).
- Sits behind the instruction fetch/scheduler. It back-pressures the scheduler with decoder_stall on read-after-write hazards.

Parameters:
- LANES, 4, number of 32-bit SIMD lanes.
- NUM_WF, 4, number of wavefront register contexts.
- WF_BITS, 2, width of wavefront_num; must equal clog2(NUM_WF).
- NUM_VREGS, 16, vector registers per wavefront; fixed at 16 by the 4-bit register fields.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high.
- inst, input, 32: instruction presented by the scheduler. It is consumed on any rising edge where decoder_stall is low.
- wavefront_num, input, WF_BITS: wavefront context of inst. Sampled together with inst.
- decoder_stall, output, 1: high means inst is not consumed this cycle and must be held stable.
- wb_valid, output, 1: a register write occurs at the next rising edge.
- wb_wf, output, WF_BITS: wavefront of the write.
- wb_reg, output, 4: destination register of the write.
- wb_data, output, LANES*32: write data; lane i occupies bits [32i+31:32i].

Behaviour:
- Encoding:
  - op = inst[31:26], vd = [25:22], vs0 = [21:18], vs1 = [17:14], imm16 = [15:0].
  - vs1 and imm overlap by design.
- Opcodes, applied per lane with all arithmetic mod 2^32:
  - 0x00 NOP.
  - 0x01 VADD: vs0+vs1.
  - 0x02 VSUB: vs0-vs1.
  - 0x03 VAND, 0x04 VOR, 0x05 VXOR.
  - 0x06 VMUL: low 32 bits of the product.
  - 0x07 VSLL: vs0<<vs1[4:0].
  - 0x08 VSRL: logical right shift.
  - 0x09 VSRA: arithmetic right shift.
  - 0x0A VMOVI: sext(imm16), no sources.
  - 0x0B VADDI: vs0+sext(imm16).
  - 0x0C VLANEID: lane index, no sources.
  - All other opcodes execute as NOP: no write, never stall.
- inst = 0 is a NOP. Idle cycles are expressed as NOPs.
- Register file:
  - NUM_WF x 16 x LANES x 32 bits.
  - Combinational read in D, synchronous write at the edge ending W.
- D-stage read bypass: if W is writing the same (wf, reg), D reads wb_data, not the array.
- Timing for an instruction accepted at edge t:
  - Operands latched into E at edge t.
  - Result latched into W at edge t+1; wb_* valid during cycle (t+1, t+2).
  - Register file updated at edge t+2.
- decoder_stall (combinational):
  - High when inst uses a source register (vs0 and/or vs1 per opcode) that equals the vd of a valid, writing E-stage instruction with the same wavefront_num.
  - The D-stage vd is not compared (no WAW hazard in order).
  - A dependent instruction issued immediately after its producer therefore sees exactly one stall cycle, then is accepted with the bypassed value.
- Stall behaviour: while stalled, a bubble (invalid, non-writing) enters E, and W advances normally.
- Different-wavefront instructions never stall against each other.
- Reset:
  - Clears all register file entries to 0 and invalidates E and W.
  - Outputs: decoder_stall=0, wb_valid=0, wb_wf=0, wb_reg=0, wb_data=0.
  - Reset asserted mid-operation discards in-flight instructions; none write.
- Shift amount is vs1[4:0] only; upper bits are ignored.

Test Plan:
- Reset, then hold inst=0 for 5 cycles -> decoder_stall=0 and wb_valid=0 throughout.
- VMOVI v1,#5 (0x28400005) then VMOVI v2,#-3 (0x2880FFFD), wf 0 -> wb_valid 2 cycles after each accept; wb_data all lanes 0x00000005, then 0xFFFFFFFD; no stall.
- After the previous step, VADD v3,v1,v2 (0x04C48000) immediately following VMOVI v2 -> decoder_stall high for exactly one cycle; wb_data lanes = 0x00000002.
- VMOVI v1,#7 on wf 1 followed by VADD v3,v1,v2 on wf 0 -> no stall; wf 0 result unaffected by the wf 1 write.
- VLANEID v4 (0x31000000), then VSLL v5,v4,v4 with one NOP between -> lanes 0,1,2,3 produce 0, 2, 8, 24.
- Assert reset while VADD is in E -> no write occurs; a subsequent read of any register returns 0 (e.g. VADDI v6,v3,#0 yields 0).
